// File: rtl/ctrl_ifetch_queue.sv
// Prefetching instruction fetch unit: a wrapping PC issues instruction-RAM reads,
// and the returned words are buffered in a small FIFO whose head is presented split into fields.
module ctrl_ifetch_queue #(
   parameter int RFAWIDTH = 5,
   parameter int DAWIDTH  = 12,
   parameter int IAWIDTH  = 6,
   parameter int DEPTH    = 4,
   localparam int INSTRWIDTH = 2 + 2*RFAWIDTH + 4*DAWIDTH,
   localparam int PW = $clog2(DEPTH),
   localparam int LW = PW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic                  flush,
   input  logic [IAWIDTH-1:0]    prog_len,
   output logic                  imem_re,
   output logic [IAWIDTH-1:0]    imem_addr,
   input  logic [INSTRWIDTH-1:0] instr_word,
   input  logic                  en_fetch,
   output logic                  iw_valid,
   output logic                  lstg_f,
   output logic                  startups_f,
   output logic [RFAWIDTH-1:0]   result_reg,
   output logic [RFAWIDTH-1:0]   error_reg,
   output logic [DAWIDTH-1:0]    data_bptr,
   output logic [DAWIDTH-1:0]    data_lptr,
   output logic [DAWIDTH-1:0]    data_hptr,
   output logic [DAWIDTH-1:0]    filt_coef_ptr,
   output logic [LW-1:0]         level,
   output logic                  pc_wrap
);

   logic [INSTRWIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic [LW-1:0]         count;
   logic                  inflight;
   logic [IAWIDTH-1:0]    pc;
   logic [IAWIDTH-1:0]    last_addr;
   logic [LW:0]           credit;
   logic                  push;
   logic                  pop;

   assign last_addr = prog_len - 1'b1;
   // An in-flight read already owns a slot, so it counts against the free space.
   assign credit    = {1'b0, count} + {{LW{1'b0}}, inflight};
   assign imem_re   = rst & run & ~flush & (prog_len != '0) & (credit < (LW+1)'(DEPTH));
   assign imem_addr = pc;

   assign push     = inflight & ~flush;
   assign pop      = en_fetch & iw_valid & ~flush;
   assign iw_valid = (count != '0);
   assign level    = count;

   assign {lstg_f, startups_f, result_reg, error_reg,
           data_bptr, data_lptr, data_hptr, filt_coef_ptr} = mem[rptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc       <= '0;
         count    <= '0;
         wptr     <= '0;
         rptr     <= '0;
         inflight <= 1'b0;
         pc_wrap  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         pc       <= '0;
         count    <= '0;
         wptr     <= '0;
         rptr     <= '0;
         inflight <= 1'b0;
         pc_wrap  <= 1'b0;
      end else begin
         inflight <= imem_re;
         pc_wrap  <= imem_re && (pc == last_addr);
         // >= also recovers when prog_len shrinks below the current pc.
         if (imem_re) pc <= (pc >= last_addr) ? '0 : pc + 1'b1;
         if (push) begin
            mem[wptr] <= instr_word;
            wptr      <= wptr + 1'b1;
         end
         if (pop) rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_ifetch_queue.sv
// Directed bench for ctrl_ifetch_queue: fill, full-queue pop, streaming with wrap,
// flush with a read in flight, single-instruction program and mid-stream reset.
module tb_ctrl_ifetch_queue;
   localparam int IW = 60;

   logic          clk = 1'b0;
   logic          rst, run, flush, en_fetch;
   logic [5:0]    prog_len;
   logic          imem_re;
   logic [5:0]    imem_addr;
   logic [IW-1:0] instr_word = '0;
   logic          iw_valid, lstg_f, startups_f, pc_wrap;
   logic [4:0]    result_reg, error_reg;
   logic [11:0]   data_bptr, data_lptr, data_hptr, filt_coef_ptr;
   logic [2:0]    level;
   logic          lstg_mode = 1'b0;
   int            n_tests = 0;
   int            n_fail = 0;
   logic [IW-1:0] head_obs;

   int fill_lvl [6] = '{0, 0, 1, 2, 3, 4};

   ctrl_ifetch_queue dut (
      .clk(clk), .rst(rst), .run(run), .flush(flush), .prog_len(prog_len),
      .imem_re(imem_re), .imem_addr(imem_addr), .instr_word(instr_word),
      .en_fetch(en_fetch), .iw_valid(iw_valid), .lstg_f(lstg_f), .startups_f(startups_f),
      .result_reg(result_reg), .error_reg(error_reg), .data_bptr(data_bptr),
      .data_lptr(data_lptr), .data_hptr(data_hptr), .filt_coef_ptr(filt_coef_ptr),
      .level(level), .pc_wrap(pc_wrap)
   );

   always #5 clk = ~clk;

   assign head_obs = {lstg_f, startups_f, result_reg, error_reg,
                      data_bptr, data_lptr, data_hptr, filt_coef_ptr};

   function automatic logic [IW-1:0] mk_word(input logic [5:0] a, input logic lst);
      return {lst, a[0], a[4:0] + 5'd1, a[4:0] + 5'd2, {6'd0, a} + 12'd3,
              {6'd0, a} + 12'd4, {6'd0, a} + 12'd5, {6'd0, a}};
   endfunction

   // Instruction RAM: one cycle read latency.
   always @(posedge clk)
      if (imem_re) instr_word <= mk_word(imem_addr, lstg_mode && (imem_addr == 6'd0));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; run = 1'b1; en_fetch = 1'b1; flush = 1'b0; prog_len = 6'd6;
      step(); step();
      check("rst_imem_re", 64'(imem_re), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      check("rst_iw_valid", 64'(iw_valid), 64'd0);
      check("rst_pc_wrap", 64'(pc_wrap), 64'd0);
      check("rst_fields", 64'(head_obs), 64'd0);

      rst = 1'b1; en_fetch = 1'b0;
      #1;
      for (int i = 0; i < 6; i++) begin
         check("fill_re", 64'(imem_re), 64'(i < 4));
         if (i < 4) check("fill_addr", 64'(imem_addr), 64'(i));
         check("fill_level", 64'(level), 64'(fill_lvl[i]));
         check("fill_valid", 64'(iw_valid), 64'(i >= 2));
         if (i >= 2) check("fill_head", 64'(head_obs), 64'(mk_word(6'd0, 1'b0)));
         if (i < 5) step();
      end

      en_fetch = 1'b1;
      #1;
      check("full_pop_re", 64'(imem_re), 64'd0);
      step();
      en_fetch = 1'b0;
      #1;
      check("full_after_level", 64'(level), 64'd3);
      check("full_after_head", 64'(head_obs), 64'(mk_word(6'd1, 1'b0)));
      check("full_after_re", 64'(imem_re), 64'd1);
      check("full_after_addr", 64'(imem_addr), 64'd4);
      step();
      check("credit_level", 64'(level), 64'd3);
      check("credit_re", 64'(imem_re), 64'd0);
      step();
      check("refill_level", 64'(level), 64'd4);
      check("refill_re", 64'(imem_re), 64'd0);

      en_fetch = 1'b1;
      #1;
      for (int k = 0; k < 12; k++) begin
         check("strm_valid", 64'(iw_valid), 64'd1);
         check("strm_head", 64'(head_obs), 64'(mk_word(6'((1 + k) % 6), 1'b0)));
         check("strm_re", 64'(imem_re), 64'(k >= 1));
         if (k >= 1) check("strm_addr", 64'(imem_addr), 64'((k + 4) % 6));
         check("strm_pc_wrap", 64'(pc_wrap), 64'(k == 2 || k == 8));
         check("strm_level", 64'(level), 64'((k == 0) ? 4 : (k == 1) ? 3 : 2));
         step();
      end

      check("flush_pre_level", 64'(level), 64'd2);
      en_fetch = 1'b0; flush = 1'b1;
      #1;
      check("flush_re", 64'(imem_re), 64'd0);
      step();
      flush = 1'b0;
      #1;
      check("flush_level", 64'(level), 64'd0);
      check("flush_valid", 64'(iw_valid), 64'd0);
      check("flush_next_re", 64'(imem_re), 64'd1);
      check("flush_next_addr", 64'(imem_addr), 64'd0);
      step();
      check("flush_stale_valid", 64'(iw_valid), 64'd0);
      step();
      check("flush_land_level", 64'(level), 64'd1);
      check("flush_land_head", 64'(head_obs), 64'(mk_word(6'd0, 1'b0)));

      flush = 1'b1; prog_len = 6'd1; lstg_mode = 1'b1;
      step();
      flush = 1'b0; en_fetch = 1'b1;
      #1;
      for (int k = 0; k < 10; k++) begin
         check("p1_re", 64'(imem_re), 64'd1);
         check("p1_addr", 64'(imem_addr), 64'd0);
         check("p1_pc_wrap", 64'(pc_wrap), 64'(k >= 1));
         check("p1_valid", 64'(iw_valid), 64'(k >= 2));
         check("p1_level", 64'(level), 64'(k >= 2));
         if (k >= 2) check("p1_head", 64'(head_obs), 64'(mk_word(6'd0, 1'b1)));
         step();
      end

      rst = 1'b0;
      #1;
      check("mid_rst_re", 64'(imem_re), 64'd0);
      step();
      check("mid_rst_level", 64'(level), 64'd0);
      check("mid_rst_valid", 64'(iw_valid), 64'd0);
      check("mid_rst_pc_wrap", 64'(pc_wrap), 64'd0);
      check("mid_rst_fields", 64'(head_obs), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
